dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//   Responder end of the pipeline's data-memory port. Serves one load/store at a time
//   from an internal word array (default 4 KB) with a programmable wait-state latency.
//   Uses a valid/ready request channel and a valid/ready response channel, so the CPU's
//   MEM stage must stall until the response is consumed. Sits between EX_MEM and MEM_WB.
// PARAMETERS
//   ADDR_W       10  word-address bits; array depth = 2**ADDR_W words of 32 bits
//   WAIT_CYCLES  2   extra cycles between request accept and memory access (0..255)
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   rst        in   1   reset, synchronous, active-high
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request this cycle
//   req_we     in   1   1 = store, 0 = load
//   req_addr   in   32  byte address; word index = req_addr[ADDR_W+1:2]
//   req_wdata  in   32  store data
//   req_be     in   4   store byte enables; be[i] selects wdata[8i+7:8i]
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   requester accepts the response
//   rsp_rdata  out  32  load data; 0 for stores
//   rsp_err    out  1   address error (only with DMEM_RESP_ERR_EN; else constant 0)
//   busy       out  1   1 while in WAIT or RESP
// BEHAVIOUR
//   - FSM states: IDLE, WAIT, RESP. req_ready = (state==IDLE); busy = (state!=IDLE).
//   - Reset: state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0.
//     req_ready reads 1 on the first cycle after rst deasserts. Reset does not clear
//     the array (sim-only initial contents are zero).
//   - IDLE: accept on posedge when req_valid & req_ready. Latch we/addr/wdata/be and load
//     counter = WAIT_CYCLES. Go to WAIT. req_* is ignored in every other state.
//   - WAIT: if counter != 0, decrement it. If counter == 0, perform the access on this edge,
//     register rsp_rdata/rsp_err, and go to RESP.
//   - Latency: rsp_valid rises exactly WAIT_CYCLES+1 edges after the accept edge.
//     With WAIT_CYCLES=0, that is 1 edge.
//   - Store: write only the lanes whose be bit is 1. be=4'b0000 writes nothing but still
//     produces a response. rsp_rdata = 0.
//   - Load: rsp_rdata = full word at the latched index. be is ignored.
//   - RESP: hold rsp_valid=1 and keep rsp_rdata/rsp_err stable until rsp_ready=1. On that
//     edge, clear rsp_valid, rsp_rdata and rsp_err to 0 and go to IDLE. No back-to-back
//     accept: at least one IDLE cycle separates transactions.
//   - rsp_ready=1 outside RESP has no effect.
//   - req_addr[1:0] is ignored (no misalignment check). Address bits above ADDR_W+1 are
//     handled per CONFIGURATION.
//   - Reset mid-operation (WAIT or RESP) has these required effects:
//     - the pending transaction is dropped;
//     - a store not yet at its access edge is never written;
//     - outputs return to their reset values on the next edge.
//   - If rst and an access edge coincide, rst wins and no write occurs.
// CONFIGURATION
//   DMEM_RESP_ERR_EN defined:
//     - req_addr[31:ADDR_W+2] != 0 makes the request an error.
//     - The access is suppressed (no write; rsp_rdata = 0) and rsp_err = 1 in RESP.
//     - Timing is unchanged.
//   DMEM_RESP_ERR_EN undefined:
//     - Upper address bits are ignored, so addresses alias modulo the array size.
//     - rsp_err is tied to 0.
// TESTING
//   1. Reset: hold rst 3 cycles with req_valid=1, req_we=1 -> no write occurs, rsp_valid=0,
//      busy=0; req_ready=1 after release.
//   2. WAIT_CYCLES=2: store 0xDEADBEEF to 0x10 with be=4'hF, accept at edge N
//      -> rsp_valid=1 after edge N+3 with rsp_rdata=0. Then load 0x10 -> rsp_rdata=0xDEADBEEF.
//   3. Byte lanes: store 0x11223344 with be=4'b0101 over 0xDEADBEEF at 0x10
//      -> a later load returns 0xDE22BE44.
//   4. Backpressure: load response with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata
//      stay stable and req_ready=0 throughout. With rsp_ready=1 -> IDLE on the next edge.
//   5. Mid-op reset: store 0x0 to 0x10, then assert rst while in WAIT with counter=1
//      -> a load of 0x10 returns 0xDE22BE44.
//   6. Address 0x1010: without the macro -> aliases to 0x10 (rsp_err=0). With
//      DMEM_RESP_ERR_EN -> rsp_err=1, rsp_rdata=0, and a store to 0x1010 leaves 0x10 unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, programmable wait states, valid/ready channels.
// Optional address-error reporting is enabled by defining DMEM_RESP_ERR_EN.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [7:0]          cnt_r;
  logic                we_r;
  logic [ADDR_W-1:0]   idx_r;
  logic [31:0]         wdata_r;
  logic [3:0]          be_r;
  logic                err_r;
  logic                rsp_valid_r;
  logic [31:0]         rsp_rdata_r;
  logic                rsp_err_r;
  logic                req_ready_r;
  logic                busy_r;
  logic                addr_err_s;
  logic                access_s;
  logic                write_en_s;
  logic [31:0]         rd_word_s;
  logic                unused_s;
  logic [31:0]         mem [0:DEPTH-1];

  // Out-of-range detection; without the feature upper bits simply alias.
`ifdef DMEM_RESP_ERR_EN
  assign addr_err_s = |req_addr[31:ADDR_W+2];
`else
  assign addr_err_s = 1'b0;
`endif

  assign unused_s   = ^{req_addr[1:0], req_addr[31:ADDR_W+2]};
  assign access_s   = (state_r == ST_WAIT) && (cnt_r == 8'd0);
  assign write_en_s = access_s && we_r && !err_r;
  assign rd_word_s  = mem[idx_r];

  assign req_ready = req_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  // Next-state decode for the IDLE/WAIT/RESP sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) state_s = ST_WAIT;
        else           state_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_r == 8'd0) state_s = ST_RESP;
        else               state_s = ST_WAIT;
      end
      ST_RESP: begin
        if (rsp_ready) state_s = ST_IDLE;
        else           state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Byte-lane store port; reset on the access edge blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && write_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_r[i]) mem[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
      end
    end
  end

  // State, request latch, wait counter and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      we_r        <= 1'b0;
      idx_r       <= {ADDR_W{1'b0}};
      wdata_r     <= 32'd0;
      be_r        <= 4'd0;
      err_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            we_r    <= req_we;
            idx_r   <= req_addr[ADDR_W+1:2];
            wdata_r <= req_wdata;
            be_r    <= req_be;
            err_r   <= addr_err_s;
            cnt_r   <= 8'(WAIT_CYCLES);
          end
        end
        ST_WAIT: begin
          if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
          end else begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= (we_r || err_r) ? 32'd0 : rd_word_s;
            rsp_err_r   <= err_r;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
          end
        end
        default: begin
          cnt_r <= 8'd0;
        end
      endcase
    end
  end

endmodule
